mont_mult_seq: RTL and testbench

MONT_MULT_SEQ -- requirements
Module: mont_mult_seq

---
 rtl/mont_mult_seq.sv | 129 ++++++++++++
 tb/tb_mont_mult_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_mult_seq.sv
// Sequential radix-2 Montgomery multiplier: s = a*b*2^-K mod n, one bit of a per enabled clock.
// ready_early is decoded from state and counter so it tracks ce gaps exactly.
module mont_mult_seq #(
  parameter int K     = 8,
  parameter int EARLY = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic [K-1:0] n,
  output logic [K-1:0] s,
  output logic         busy,
  output logic         done,
  output logic         ready_early
);
  localparam int IW = $clog2(K + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam logic [IW-1:0] LAST_I         = IW'(K - 1);
  localparam logic [IW-1:0] EARLY_I        = IW'(K - EARLY);
  localparam logic          EARLY_AT_FINAL = (EARLY == 0);

  logic [1:0]    state_r;
  logic [K-1:0]  a_r;
  logic [K-1:0]  b_r;
  logic [K-1:0]  n_r;
  logic [K+1:0]  acc_r;
  logic [IW-1:0] cnt_r;
  logic [K-1:0]  s_r;
  logic          busy_r;
  logic          done_r;
  logic          early_r;

  logic [K+1:0]  addend_b_s;
  logic [K+1:0]  sum_ab_s;
  logic [K+1:0]  addend_n_s;
  logic [K+1:0]  sum_all_s;
  logic [K+1:0]  acc_next_s;
  logic [K-1:0]  reduced_s;
  logic          acc_ge_n_s;

  // Iteration datapath and final conditional subtraction (acc < 2n, so K low bits of acc-n suffice)
  always_comb begin
    addend_b_s = {(K+2){1'b0}};
    addend_n_s = {(K+2){1'b0}};
    if (a_r[0]) begin
      addend_b_s = {2'b00, b_r};
    end else begin
      addend_b_s = {(K+2){1'b0}};
    end
    sum_ab_s = acc_r + addend_b_s;
    if (sum_ab_s[0]) begin
      addend_n_s = {2'b00, n_r};
    end else begin
      addend_n_s = {(K+2){1'b0}};
    end
    sum_all_s  = sum_ab_s + addend_n_s;
    acc_next_s = sum_all_s >> 1'b1;
    acc_ge_n_s = (acc_r >= {2'b00, n_r});
    reduced_s  = acc_r[K-1:0] - n_r;
  end

  // Control FSM, operand registers and registered outputs; everything holds while ce is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_r     <= {K{1'b0}};
      b_r     <= {K{1'b0}};
      n_r     <= {K{1'b0}};
      acc_r   <= {(K+2){1'b0}};
      cnt_r   <= {IW{1'b0}};
      s_r     <= {K{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      early_r <= 1'b0;
    end else if (ce) begin
      case (state_r)
        ST_IDLE: begin
          done_r  <= 1'b0;
          early_r <= 1'b0;
          // A start coinciding with the done pulse is dropped, not queued
          if (start && !done_r) begin
            a_r     <= a;
            b_r     <= b;
            n_r     <= n;
            acc_r   <= {(K+2){1'b0}};
            cnt_r   <= {IW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc_r   <= acc_next_s;
          a_r     <= a_r >> 1'b1;
          cnt_r   <= cnt_r + {{(IW-1){1'b0}}, 1'b1};
          early_r <= (cnt_r == EARLY_I);
          done_r  <= 1'b0;
          if (cnt_r == LAST_I) begin
            state_r <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          s_r     <= acc_ge_n_s ? reduced_s : acc_r[K-1:0];
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          early_r <= EARLY_AT_FINAL;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          early_r <= 1'b0;
        end
      endcase
    end
  end

  assign s           = s_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign ready_early = early_r;
endmodule

// File: tb/tb_mont_mult_seq.sv
// Bench for mont_mult_seq: K=8/EARLY=1 vector table with corner sequences,
// plus K=16/EARLY=3 random operands against an independent modular-inverse model.
module tb_mont_mult_seq;
  logic        clk;
  logic        rst_n;
  logic        ce;

  logic        start8;
  logic [7:0]  a8, b8, n8, s8;
  logic        busy8, done8, re8;

  logic        start16;
  logic [15:0] a16, b16, n16, s16;
  logic        busy16, done16, re16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic [7:0]  last_s8;

  typedef struct {
    bit [7:0] a;
    bit [7:0] b;
    bit [7:0] exp;
    bit       toggle;
    bit       poke;
    bit       start_at_done;
  } vec_t;
  vec_t vecs[7];

  mont_mult_seq #(.K(8), .EARLY(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start8),
    .a(a8), .b(b8), .n(n8), .s(s8),
    .busy(busy8), .done(done8), .ready_early(re8)
  );

  mont_mult_seq #(.K(16), .EARLY(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start16),
    .a(a16), .b(b16), .n(n16), .s(s16),
    .busy(busy16), .done(done16), .ready_early(re16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // r such that r * 2^k == 1 (mod nn), found by search
  function automatic longint inv_pow2(input longint nn, input int k);
    longint rp;
    rp = (longint'(1) << k) % nn;
    for (longint r = 1; r < nn; r++) begin
      if ((r * rp) % nn == 1) return r;
    end
    return 0;
  endfunction

  task automatic op8(input vec_t v);
    int en;
    int cyc;
    logic [7:0] exp_s;
    q8.push_back(v.exp);
    ce = 1'b1; a8 = v.a; b8 = v.b; n8 = 8'd131; start8 = 1'b1;
    step();
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; n8 = 8'd77;
    en = 0;
    cyc = 0;
    forever begin
      chk("busy8", busy8, en < 9);
      chk("ready_early8", re8, en == 8);
      chk("done8", done8, en == 9);
      if (en >= 9) break;
      chk("s8_hold", s8, last_s8);
      if (cyc > 60) begin
        n_checks++; n_fail++;
        $display("FAIL timeout8: got %0d enabled edges, expected 9", en);
        break;
      end
      ce = v.toggle ? ((cyc % 2) == 1) : 1'b1;
      start8 = v.poke && (cyc == 2);
      if (v.poke && cyc == 2) a8 = 8'd7;
      @(posedge clk);
      if (ce) en++;
      #1;
      cyc++;
      start8 = 1'b0;
    end
    exp_s = q8.pop_front();
    chk("s8_result", s8, exp_s);
    last_s8 = exp_s;
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev);
    int en;
    int cyc;
    int re_en;
    logic [15:0] exp_s;
    q16.push_back(ev);
    ce = 1'b1; a16 = av; b16 = bv; n16 = 16'd65521; start16 = 1'b1;
    step();
    start16 = 1'b0; a16 = ~av;
    en = 0; cyc = 0; re_en = -1;
    while (!done16 && cyc < 200) begin
      if (re16 && re_en < 0) re_en = en;
      ce = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      if (ce) en++;
      #1;
      cyc++;
    end
    exp_s = q16.pop_front();
    chk("done16_latency", en, 17);
    chk("ready_early16_at", re_en, 14);
    chk("s16_result", s16, exp_s);
    ce = 1'b1;
    step();
  endtask

  initial begin
    longint rinv16;
    longint av, bv, ev;
    int dones;

    vecs[0] = '{a: 8'd25,  b: 8'd36,  exp: 8'd112, toggle: 1'b0, poke: 1'b0, start_at_done: 1'b0};
    vecs[1] = '{a: 8'd1,   b: 8'd1,   exp: 8'd109, toggle: 1'b0, poke: 1'b0, start_at_done: 1'b1};
    vecs[2] = '{a: 8'd130, b: 8'd130, exp: 8'd109, toggle: 1'b0, poke: 1'b0, start_at_done: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 8'd77,  exp: 8'd0,   toggle: 1'b0, poke: 1'b0, start_at_done: 1'b0};
    vecs[4] = '{a: 8'd25,  b: 8'd36,  exp: 8'd112, toggle: 1'b1, poke: 1'b0, start_at_done: 1'b0};
    vecs[5] = '{a: 8'd25,  b: 8'd36,  exp: 8'd112, toggle: 1'b0, poke: 1'b1, start_at_done: 1'b0};
    vecs[6] = '{a: 8'd1,   b: 8'd1,   exp: 8'd109, toggle: 1'b0, poke: 1'b0, start_at_done: 1'b0};

    rst_n = 1'b1; ce = 1'b0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; n8 = 8'd131;
    start16 = 1'b0; a16 = 16'd0; b16 = 16'd0; n16 = 16'd65521;
    last_s8 = 8'd0;
    rinv16 = inv_pow2(64'd65521, 16);

    // asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_s8", s8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_re8", re8, 0);
    chk("rst_s16", s16, 0);
    chk("rst_busy16", busy16, 0);
    step();
    step();
    rst_n = 1'b1;

    // first start sampled on the edge right after release
    for (int i = 0; i < 7; i++) begin
      op8(vecs[i]);
      ce = 1'b0;
      step();
      chk("done8_held", done8, 1);
      chk("s8_held", s8, last_s8);
      ce = 1'b1;
      start8 = vecs[i].start_at_done; a8 = 8'd3; b8 = 8'd3; n8 = 8'd131;
      step();
      start8 = 1'b0;
      chk("done8_clear", done8, 0);
      chk("start_at_done_ignored", busy8, 0);
    end

    // reset mid-computation
    ce = 1'b1; a8 = 8'd25; b8 = 8'd36; n8 = 8'd131; start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_s8", s8, 0);
    chk("abort_re8", re8, 0);
    last_s8 = 8'd0;
    repeat (2) step();
    rst_n = 1'b1;
    dones = 0;
    repeat (14) begin
      step();
      if (done8) dones++;
    end
    chk("no_done_after_abort", dones, 0);
    op8(vecs[0]);
    ce = 1'b1;
    step();

    // K=16 random operands with random ce gaps
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin av = 0; bv = 0; end
      else if (i == 1) begin av = 65520; bv = 65520; end
      else if (i == 2) begin av = 1; bv = 1; end
      else begin
        av = longint'($urandom_range(0, 65520));
        bv = longint'($urandom_range(0, 65520));
      end
      ev = (((av * bv) % 65521) * rinv16) % 65521;
      op16(av[15:0], bv[15:0], ev[15:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
